// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common-data-bus arbiter: FU indices, the broadcast
// packet, and the round-robin successor helper.
package cdb_arbiter_pkg;

  localparam int TAG_W_DEF  = 5;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_FU     = 3;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_LSU = 2'd2
  } fu_e;

  typedef struct packed {
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] data;
  } cdb_pkt;

  function automatic fu_e fu_next(fu_e f);
    case (f)
      FU_ALU:  return FU_MUL;
      FU_MUL:  return FU_LSU;
      default: return FU_ALU;
    endcase
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-FU completion queue. ready_o comes straight from the registered count so
// the FU handshake has no combinational dependence on any input.
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int W     = TAG_W_DEF + DATA_W_DEF,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         ready_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign ready_o = (count < CW'(DEPTH));
  assign empty_o = (count == '0);
  assign head_o  = mem[rd_ptr];
  assign push_ok = push_i & ready_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= push_data_i;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter merging ALU/MUL/LSU completions onto one registered
// common data bus, one broadcast per cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              flush_i,
  input  logic              alu_done_i,
  input  logic [TAG_W-1:0]  alu_tag_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              mul_done_i,
  input  logic [TAG_W-1:0]  mul_tag_i,
  input  logic [DATA_W-1:0] mul_data_i,
  input  logic              lsu_done_i,
  input  logic [TAG_W-1:0]  lsu_tag_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  output logic              alu_ready_o,
  output logic              mul_ready_o,
  output logic              lsu_ready_o,
  output logic              cdb_en_o,
  output logic [TAG_W-1:0]  cdb_tag_o,
  output logic [DATA_W-1:0] cdb_data_o
);

  localparam int PKT_W = TAG_W + DATA_W;

  logic [PKT_W-1:0] head [NUM_FU];
  logic [NUM_FU-1:0] empty, ready, push, pop;
  logic [PKT_W-1:0]  push_data [NUM_FU];

  fu_e  ptr, grant_fu, cand;
  logic grant_vld;

  assign push      = {lsu_done_i, mul_done_i, alu_done_i};
  assign push_data[0] = {alu_tag_i, alu_data_i};
  assign push_data[1] = {mul_tag_i, mul_data_i};
  assign push_data[2] = {lsu_tag_i, lsu_data_i};

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
    cdb_fifo #(.W(PKT_W), .DEPTH(DEPTH)) u_fifo (
      .clk_i       (clk_i),
      .reset_ni    (reset_ni),
      .flush_i     (flush_i),
      .push_i      (push[g]),
      .push_data_i (push_data[g]),
      .pop_i       (pop[g]),
      .head_o      (head[g]),
      .empty_o     (empty[g]),
      .ready_o     (ready[g])
    );
  end

  assign alu_ready_o = ready[0];
  assign mul_ready_o = ready[1];
  assign lsu_ready_o = ready[2];

  // First non-empty queue at or after the priority pointer wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_fu  = FU_ALU;
    cand      = ptr;
    for (int k = 0; k < NUM_FU; k++) begin
      if (!grant_vld && !empty[cand]) begin
        grant_vld = 1'b1;
        grant_fu  = cand;
      end
      cand = fu_next(cand);
    end
  end

  assign pop = grant_vld ? (NUM_FU'(1) << grant_fu) : '0;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ptr        <= FU_ALU;
      cdb_en_o   <= 1'b0;
      cdb_tag_o  <= '0;
      cdb_data_o <= '0;
    end else if (flush_i) begin
      ptr      <= FU_ALU;
      cdb_en_o <= 1'b0;
    end else if (grant_vld) begin
      ptr                     <= fu_next(grant_fu);
      cdb_en_o                <= 1'b1;
      {cdb_tag_o, cdb_data_o} <= head[grant_fu];
    end else begin
      cdb_en_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic              clk_i = 1'b0;
  logic              reset_ni;
  logic              flush_i;
  logic              done_in [3];
  logic [TAG_W-1:0]  tag_in  [3];
  logic [DATA_W-1:0] data_in [3];
  logic              alu_ready_o, mul_ready_o, lsu_ready_o;
  logic              cdb_en_o;
  logic [TAG_W-1:0]  cdb_tag_o;
  logic [DATA_W-1:0] cdb_data_o;

  always #5 clk_i = ~clk_i;

  cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .flush_i    (flush_i),
    .alu_done_i (done_in[0]),
    .alu_tag_i  (tag_in[0]),
    .alu_data_i (data_in[0]),
    .mul_done_i (done_in[1]),
    .mul_tag_i  (tag_in[1]),
    .mul_data_i (data_in[1]),
    .lsu_done_i (done_in[2]),
    .lsu_tag_i  (tag_in[2]),
    .lsu_data_i (data_in[2]),
    .alu_ready_o(alu_ready_o),
    .mul_ready_o(mul_ready_o),
    .lsu_ready_o(lsu_ready_o),
    .cdb_en_o   (cdb_en_o),
    .cdb_tag_o  (cdb_tag_o),
    .cdb_data_o (cdb_data_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: one packet queue per FU, a round-robin pointer, and the
  // last broadcast.
  cdb_pkt            q  [3][$];
  cdb_pkt            sc [3][$];
  int                rr;
  logic              exp_en;
  logic [TAG_W-1:0]  exp_tag;
  logic [DATA_W-1:0] exp_data;
  bit                acc [3];

  task automatic chk(string nm, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  function automatic logic ready_of(int i);
    case (i)
      0:       return alu_ready_o;
      1:       return mul_ready_o;
      default: return lsu_ready_o;
    endcase
  endfunction

  task automatic check_all();
    chk("cdb_en", 64'(cdb_en_o), 64'(exp_en));
    chk("cdb_tag", 64'(cdb_tag_o), 64'(exp_tag));
    chk("cdb_data", 64'(cdb_data_o), 64'(exp_data));
    for (int i = 0; i < 3; i++)
      chk($sformatf("ready%0d", i), 64'(ready_of(i)), 64'(q[i].size() < DEPTH));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      sc[i].delete();
      done_in[i] = 1'b0;
      acc[i]     = 1'b0;
    end
    rr = 0; exp_en = 1'b0; exp_tag = '0; exp_data = '0;
  endtask

  task automatic step();
    int gi;
    cdb_pkt p;
    @(posedge clk_i);
    for (int i = 0; i < 3; i++)
      acc[i] = done_in[i] && !flush_i && (q[i].size() < DEPTH);
    if (flush_i) begin
      for (int i = 0; i < 3; i++) q[i].delete();
      exp_en = 1'b0;
      rr = 0;
    end else begin
      gi = -1;
      for (int k = 0; k < 3; k++)
        if (gi < 0 && q[(rr + k) % 3].size() > 0) gi = (rr + k) % 3;
      if (gi >= 0) begin
        p = q[gi].pop_front();
        exp_en = 1'b1; exp_tag = p.tag; exp_data = p.data;
        rr = (gi + 1) % 3;
      end else begin
        exp_en = 1'b0;
      end
      for (int i = 0; i < 3; i++)
        if (acc[i]) begin
          p.tag = tag_in[i]; p.data = data_in[i];
          q[i].push_back(p);
        end
    end
    #1 check_all();
  endtask

  // FU behaviour: hold a completion until accepted, then present the next one.
  task automatic feed();
    cdb_pkt p;
    for (int i = 0; i < 3; i++) begin
      if (acc[i]) done_in[i] = 1'b0;
      if (!done_in[i] && sc[i].size() > 0) begin
        p = sc[i].pop_front();
        done_in[i] = 1'b1; tag_in[i] = p.tag; data_in[i] = p.data;
      end
    end
  endtask

  function automatic bit idle();
    for (int i = 0; i < 3; i++)
      if (sc[i].size() > 0 || done_in[i] || q[i].size() > 0) return 1'b0;
    return !exp_en;
  endfunction

  task automatic run_idle(string nm, int max_n);
    int n = 0;
    while (!idle() && n < max_n) begin
      step(); feed(); n++;
    end
    chk({nm, "_drain"}, 64'(idle()), 64'd1);
  endtask

  function automatic cdb_pkt mk(int t, int d);
    cdb_pkt p;
    p.tag = TAG_W'(t); p.data = DATA_W'(d);
    return p;
  endfunction

  task automatic pulse_flush();
    flush_i = 1'b1; step(); flush_i = 1'b0;
  endtask

  initial begin
    int n, k;
    flush_i  = 1'b0;
    reset_ni = 1'b0;
    for (int i = 0; i < 3; i++) begin tag_in[i] = '0; data_in[i] = '0; end
    model_reset();
    #12;
    check_all();
    @(negedge clk_i) reset_ni = 1'b1;

    // Single completion: visible after the second edge only.
    sc[0].push_back(mk(7, 'h11)); feed();
    step(); feed();
    step(); feed();
    chk("single_en", 64'(cdb_en_o), 64'd1);
    chk("single_tag", 64'(cdb_tag_o), 64'd7);
    step(); feed();
    chk("single_after", 64'(cdb_en_o), 64'd0);

    // Contention from pointer=ALU.
    pulse_flush();
    sc[0].push_back(mk(1, 'hA1)); sc[1].push_back(mk(2, 'hB2)); sc[2].push_back(mk(3, 'hC3));
    feed();
    run_idle("contend", 10);

    // MUL fills while LSU holds priority; third MUL done is rejected then retried.
    pulse_flush();
    sc[1].push_back(mk(10, 'h10)); feed();
    run_idle("prime", 10);
    sc[2].push_back(mk(20, 'h20)); sc[2].push_back(mk(21, 'h21));
    sc[1].push_back(mk(4, 'h4)); sc[1].push_back(mk(5, 'h5)); sc[1].push_back(mk(6, 'h6));
    feed(); step(); feed(); step(); feed();
    chk("full_mul_ready", 64'(mul_ready_o), 64'd0);
    run_idle("full", 20);

    // Fairness against a streaming ALU; tag 0 exercised as an ordinary tag.
    pulse_flush();
    for (int t = 0; t < 10; t++) sc[0].push_back(mk(11 + t, t * 3));
    feed(); step(); feed();
    sc[1].push_back(mk(9, 'h99)); feed();
    n = 0;
    do begin step(); n++; end while (!acc[1] && n < 4);
    feed();
    chk("fair_accept", 64'(acc[1]), 64'd1);
    k = 0;
    while (!(cdb_en_o && cdb_tag_o == 9) && k < 5) begin step(); feed(); k++; end
    chk("fair_latency_le2", 64'(k <= 2), 64'd1);
    sc[2].push_back(mk(0, 'h0)); feed();
    run_idle("fair", 30);

    // Flush with several entries queued.
    sc[0].push_back(mk(30, 'h30)); sc[0].push_back(mk(31, 'h31));
    sc[1].push_back(mk(32, 'h32)); sc[1].push_back(mk(33, 'h33));
    sc[2].push_back(mk(34, 'h34)); sc[2].push_back(mk(35, 'h35));
    feed(); step(); feed(); step(); feed();
    for (int i = 0; i < 3; i++) begin sc[i].delete(); done_in[i] = 1'b0; end
    pulse_flush();
    chk("flush_en", 64'(cdb_en_o), 64'd0);
    chk("flush_ready", 64'({alu_ready_o, mul_ready_o, lsu_ready_o}), 64'h7);
    repeat (4) step();

    // Asynchronous reset between edges with queues occupied.
    sc[0].push_back(mk(40, 'h40)); sc[0].push_back(mk(41, 'h41)); sc[1].push_back(mk(42, 'h42));
    feed(); step(); feed(); step(); feed();
    #2 reset_ni = 1'b0;
    #1;
    chk("arst_en", 64'(cdb_en_o), 64'd0);
    chk("arst_tag", 64'(cdb_tag_o), 64'd0);
    chk("arst_data", 64'(cdb_data_o), 64'd0);
    chk("arst_ready", 64'({alu_ready_o, mul_ready_o, lsu_ready_o}), 64'h7);
    model_reset();
    @(negedge clk_i) reset_ni = 1'b1;
    step();

    // Random traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      step();
      flush_i = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < 3; i++) begin
        if (acc[i]) done_in[i] = 1'b0;
        if (!done_in[i] && $urandom_range(0, 99) < 45) begin
          done_in[i] = 1'b1;
          tag_in[i]  = TAG_W'($urandom_range(0, 31));
          data_in[i] = $urandom;
        end
      end
    end
    flush_i = 1'b0;
    run_idle("random", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
